// File: rtl/set_assoc_cache.sv
// set_assoc_cache: N-way set-associative write-through data cache, one word per line,
//   tree pseudo-LRU replacement (invalid ways first), single-cycle flush.
// Latency: load hit acks in the request cycle; load miss / store ack one cycle after mem_ack_i.
// Backpressure: requester holds req_i until ack_o; mem_req_o and its qualifiers hold until mem_ack_i.
// Ports: clk, rst_n (async, active low); CPU side req_i/we_i/addr_i/wdata_i/flush_i -> ack_o/rdata_o;
//   memory side mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o, mem_rdata_i/mem_ack_i;
//   hit_count_o/miss_count_o load statistics.
// Optional feature macro: CACHE_STATS_EN builds saturating hit/miss counters (else tied to 0).
module set_assoc_cache #(
  parameter int WAYS       = 4,
  parameter int SET_WIDTH  = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int TAG_WIDTH = ADDR_WIDTH - SET_WIDTH - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  flush_i,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic [31:0]           hit_count_o,
  output logic [31:0]           miss_count_o
);
  localparam int SETS  = 1 << SET_WIDTH;
  localparam int WAY_W = $clog2(WAYS);
  localparam int NODES = WAYS - 1;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESP} state_e;

  // Tree node at level l serves the ways whose low l index bits equal prefix p;
  // it lives at index (2^l - 1 + p) and its bit is index bit l of the victim half.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [NODES-1:0] bits);
    logic [WAY_W-1:0] p;
    logic [NODES-1:0] sh;
    p = '0;
    for (int l = 0; l < WAY_W; l++) begin
      sh   = bits >> ((1 << l) - 1 + int'(p));
      p[l] = sh[0];
    end
    return p;
  endfunction

  // Point every node on the path to way w at the opposite half.
  function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                  input logic [WAY_W-1:0] w);
    logic [NODES-1:0] r;
    logic [WAY_W-1:0] pre;
    logic             away;
    int               idx;
    r = bits;
    for (int l = 0; l < WAY_W; l++) begin
      pre  = w & WAY_W'((1 << l) - 1);
      idx  = (1 << l) - 1 + int'(pre);
      away = ~w[l];
      r    = (r & ~(NODES'(1) << idx)) | (NODES'(away) << idx);
    end
    return r;
  endfunction

  state_e state_q, state_d;
  logic [SETS-1:0][WAYS-1:0]  valid_q;
  logic [SETS-1:0][NODES-1:0] plru_q;
  logic [TAG_WIDTH-1:0]       tag_q  [SETS][WAYS];
  logic [DATA_WIDTH-1:0]      data_q [SETS][WAYS];

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, resp_q;
  logic                  we_q;
  logic [WAY_W-1:0]      victim_q;

  // The request is held until ack, but the latched copy keeps lookup stable in REFILL/WRITE.
  logic [ADDR_WIDTH-1:0] lk_addr;
  logic [SET_WIDTH-1:0]  lk_set;
  logic [TAG_WIDTH-1:0]  lk_tag;
  logic                  unused_addr_lsbs;
  assign lk_addr          = (state_q == IDLE) ? addr_i : addr_q;
  assign lk_set           = lk_addr[SET_WIDTH+1:2];
  assign lk_tag           = lk_addr[ADDR_WIDTH-1:SET_WIDTH+2];
  assign unused_addr_lsbs = ^lk_addr[1:0];

  logic                  hit;
  logic [WAY_W-1:0]      hit_way, victim;
  logic [DATA_WIDTH-1:0] hit_data;
  logic                  found_free;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end
  assign hit_data = data_q[lk_set][hit_way];

  always_comb begin
    victim     = plru_victim(plru_q[lk_set]);
    found_free = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_free && !valid_q[lk_set][w]) begin
        victim     = WAY_W'(w);
        found_free = 1'b1;
      end
    end
  end

  logic             flush_en, latch_en, touch_en, refill_wr, store_upd;
  logic [WAY_W-1:0] touch_way;

  always_comb begin
    state_d   = state_q;
    ack_o     = 1'b0;
    rdata_o   = '0;
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    flush_en  = 1'b0;
    latch_en  = 1'b0;
    touch_en  = 1'b0;
    touch_way = hit_way;
    refill_wr = 1'b0;
    store_upd = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_i) begin
          flush_en = 1'b1;
        end else if (req_i) begin
          if (we_i) begin
            latch_en = 1'b1;
            state_d  = WRITE;
          end else if (hit) begin
            ack_o    = 1'b1;
            rdata_o  = hit_data;
            touch_en = 1'b1;
          end else begin
            latch_en = 1'b1;
            state_d  = REFILL;
          end
        end
      end
      REFILL: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          refill_wr = 1'b1;
          touch_en  = 1'b1;
          touch_way = victim_q;
          state_d   = RESP;
        end
      end
      WRITE: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        if (mem_ack_i) begin
          // Write-through, no allocate: only an existing copy is refreshed.
          store_upd = hit;
          touch_en  = hit;
          state_d   = RESP;
        end
      end
      RESP: begin
        ack_o   = 1'b1;
        rdata_o = we_q ? '0 : resp_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      victim_q <= '0;
      resp_q   <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        addr_q   <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
        wdata_q  <= wdata_i;
        we_q     <= we_i;
        victim_q <= victim;
      end
      if (refill_wr) resp_q <= mem_rdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      plru_q  <= '0;
    end else if (flush_en) begin
      valid_q <= '0;
      plru_q  <= '0;
    end else begin
      if (refill_wr) valid_q[lk_set][victim_q] <= 1'b1;
      if (touch_en)  plru_q[lk_set] <= plru_touch(plru_q[lk_set], touch_way);
    end
  end

  // Tag/data arrays need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (refill_wr) begin
      tag_q[lk_set][victim_q]  <= lk_tag;
      data_q[lk_set][victim_q] <= mem_rdata_i;
    end
    if (store_upd) data_q[lk_set][hit_way] <= wdata_q;
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        stat_hit, stat_miss;
  // In IDLE an ack can only be a load hit.
  assign stat_hit  = (state_q == IDLE) && ack_o;
  assign stat_miss = (state_q == IDLE) && (state_d == REFILL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (stat_hit  && (hit_cnt_q  != '1)) hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (stat_miss && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end
  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`else
  assign hit_count_o  = '0;
  assign miss_count_o = '0;
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
module tb_set_assoc_cache;
  localparam int WAYS = 4;
  localparam int SETS = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0, we_i = 1'b0, flush_i = 1'b0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic        ack_o, mem_req_o, mem_we_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;
  logic [31:0] hit_count_o, miss_count_o;

  always #5 clk = ~clk;

  set_assoc_cache dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .flush_i(flush_i), .ack_o(ack_o), .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem [logic [31:0]];
  int mem_lat = 0;
  int req_cycles = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], 16'hC0DE};
  endfunction

  // Acks after mem_lat wait states; mem_lat=0 acks in the cycle mem_req_o rises.
  always @(posedge clk) begin
    #1;
    if (mem_ack_i || !mem_req_o) req_cycles = 0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    if (mem_req_o) begin
      req_cycles++;
      if (req_cycles > mem_lat) begin
        mem_ack_i = 1'b1;
        if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
        else          mem_rdata_i = mem_rd(mem_addr_o);
      end
    end
  end

  // ---------------- reference model ----------------
  // Each way remembers when it was last used; the tree victim is found by
  // repeatedly choosing the half (split on way-index bit l) whose newest use is older.
  bit          mv     [SETS][WAYS];
  int          mtag   [SETS][WAYS];
  logic [31:0] mdata  [SETS][WAYS];
  int          mstamp [SETS][WAYS];
  int          mclock = 0;
  int          m_hits = 0, m_misses = 0;

  task automatic model_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        mv[s][w] = 1'b0;
        mstamp[s][w] = 0;
      end
  endtask

  function automatic int model_victim(input int s);
    int p, t0, t1;
    for (int w = 0; w < WAYS; w++) if (!mv[s][w]) return w;
    p = 0;
    for (int half = 1; half < WAYS; half *= 2) begin
      t0 = 0; t1 = 0;
      for (int w = 0; w < WAYS; w++) begin
        if (w % (2 * half) == p && mstamp[s][w] > t0) t0 = mstamp[s][w];
        if (w % (2 * half) == p + half && mstamp[s][w] > t1) t1 = mstamp[s][w];
      end
      if (t1 < t0) p += half;
    end
    return p;
  endfunction

  task automatic model_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic use_mem);
    int s, t, w;
    s = int'(addr[4:2]);
    t = int'(addr >> 5);
    w = -1;
    for (int i = 0; i < WAYS; i++) if (mv[s][i] && mtag[s][i] == t) w = i;
    rd = '0;
    if (!we && w >= 0) begin
      lat = 0; use_mem = 1'b0; rd = mdata[s][w];
      mstamp[s][w] = ++mclock;
      m_hits++;
    end else if (!we) begin
      w = model_victim(s);
      mv[s][w] = 1'b1; mtag[s][w] = t; mdata[s][w] = mem_rd(addr & ~32'd3);
      mstamp[s][w] = ++mclock;
      m_misses++;
      lat = 2 + mem_lat; use_mem = 1'b1; rd = mdata[s][w];
    end else begin
      lat = 2 + mem_lat; use_mem = 1'b1;
      if (w >= 0) begin
        mdata[s][w] = wd;
        mstamp[s][w] = ++mclock;
      end
    end
  endtask

  function automatic logic [31:0] stat_exp(input int v);
`ifdef CACHE_STATS_EN
    return 32'(v);
`else
    return 32'(v) & 32'd0;
`endif
  endfunction

  // ---------------- driver ----------------
  int          op_lat;
  logic [31:0] op_rd, c1_addr, c1_wdata;
  logic        op_mem_seen, c1_req, c1_we;

  task automatic do_op(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    int cyc;
    bit got;
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd;
    cyc = 0; got = 0; op_mem_seen = 0; op_rd = '0;
    c1_req = 0; c1_addr = '0; c1_we = 0; c1_wdata = '0;
    while (!got && cyc < 64) begin
      @(negedge clk);
      if (mem_req_o) op_mem_seen = 1'b1;
      if (cyc == 1) begin
        c1_req = mem_req_o; c1_addr = mem_addr_o; c1_we = mem_we_o; c1_wdata = mem_wdata_o;
      end
      if (ack_o) begin got = 1; op_rd = rdata_o; end
      @(posedge clk); #1;
      if (!got) cyc++;
    end
    req_i = 1'b0; we_i = 1'b0;
    op_lat = cyc;
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL op_timeout: no ack for addr 0x%08h within %0d cycles, ack required", addr, cyc);
    end
  endtask

  task automatic check_op(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd);
    int e_lat;
    logic [31:0] e_rd;
    logic e_mem;
    model_op(we, addr, wd, e_lat, e_rd, e_mem);
    do_op(we, addr, wd);
    check($sformatf("%s_lat_%08h", tag, addr), 32'(op_lat), 32'(e_lat));
    check($sformatf("%s_memreq_%08h", tag, addr), 32'(op_mem_seen), 32'(e_mem));
    if (!we) check($sformatf("%s_rdata_%08h", tag, addr), op_rd, e_rd);
    if (e_mem) begin
      check($sformatf("%s_c1addr_%08h", tag, addr), c1_addr, addr & ~32'd3);
      check($sformatf("%s_c1we_%08h", tag, addr), 32'(c1_we), 32'(we));
      if (we) check($sformatf("%s_c1wdata_%08h", tag, addr), c1_wdata, wd);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rd;
    logic        use_mem;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int dl; logic [31:0] drd; logic dm;
    int t_hits, t_misses;
    tbl[0]  = '{1'b0, 32'h10,  32'h0,        2, 32'hDEADBEEF, 1'b1};
    tbl[1]  = '{1'b0, 32'h10,  32'h0,        0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b0, 32'h30,  32'h0,        2, 32'h0030C0DE, 1'b1};
    tbl[3]  = '{1'b0, 32'h50,  32'h0,        2, 32'h0050C0DE, 1'b1};
    tbl[4]  = '{1'b0, 32'h70,  32'h0,        2, 32'h0070C0DE, 1'b1};
    tbl[5]  = '{1'b0, 32'h10,  32'h0,        0, 32'hDEADBEEF, 1'b0};
    tbl[6]  = '{1'b0, 32'h90,  32'h0,        2, 32'h0090C0DE, 1'b1};
    tbl[7]  = '{1'b0, 32'h10,  32'h0,        0, 32'hDEADBEEF, 1'b0};
    tbl[8]  = '{1'b0, 32'h50,  32'h0,        0, 32'h0050C0DE, 1'b0};
    tbl[9]  = '{1'b0, 32'h70,  32'h0,        0, 32'h0070C0DE, 1'b0};
    tbl[10] = '{1'b1, 32'h10,  32'h12345678, 2, 32'h0,        1'b1};
    tbl[11] = '{1'b0, 32'h10,  32'h0,        0, 32'h12345678, 1'b0};
    tbl[12] = '{1'b0, 32'h30,  32'h0,        2, 32'h0030C0DE, 1'b1};
    tbl[13] = '{1'b1, 32'h200, 32'hABCD0001, 2, 32'h0,        1'b1};
    tbl[14] = '{1'b0, 32'h200, 32'h0,        2, 32'hABCD0001, 1'b1};

    mem[32'h10] = 32'hDEADBEEF;
    model_clear();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(ack_o), 0);
    check("rst_mem_req", 32'(mem_req_o), 0);
    check("rst_mem_we", 32'(mem_we_o), 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_mem_wdata", mem_wdata_o, 0);
    check("rst_hits", hit_count_o, 0);
    check("rst_misses", miss_count_o, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table, zero-wait memory
    mem_lat = 0; t_hits = 0; t_misses = 0;
    for (int i = 0; i < 15; i++) begin
      model_op(tbl[i].we, tbl[i].addr, tbl[i].wdata, dl, drd, dm);
      do_op(tbl[i].we, tbl[i].addr, tbl[i].wdata);
      check($sformatf("tbl%0d_lat", i), 32'(op_lat), 32'(tbl[i].lat));
      check($sformatf("tbl%0d_memreq", i), 32'(op_mem_seen), 32'(tbl[i].use_mem));
      if (!tbl[i].we) begin
        check($sformatf("tbl%0d_rdata", i), op_rd, tbl[i].rd);
        if (tbl[i].use_mem) t_misses++; else t_hits++;
      end
      if (tbl[i].use_mem) begin
        check($sformatf("tbl%0d_c1req", i), 32'(c1_req), 1);
        check($sformatf("tbl%0d_c1addr", i), c1_addr, tbl[i].addr);
        check($sformatf("tbl%0d_c1we", i), 32'(c1_we), 32'(tbl[i].we));
        if (tbl[i].we) check($sformatf("tbl%0d_c1wdata", i), c1_wdata, tbl[i].wdata);
      end
      if (i == 1) begin
        check("stats_t1_hits", hit_count_o, stat_exp(1));
        check("stats_t1_misses", miss_count_o, stat_exp(1));
      end
    end
    check("tbl_hits", hit_count_o, stat_exp(t_hits));
    check("tbl_misses", miss_count_o, stat_exp(t_misses));

    // Flush with simultaneous request; refill must restart from way 0
    check_op("fill", 1'b0, 32'h10, 0);
    check_op("fill", 1'b0, 32'h30, 0);
    check_op("fill", 1'b0, 32'h50, 0);
    check_op("fill", 1'b0, 32'h70, 0);
    flush_i = 1'b1; req_i = 1'b1; we_i = 1'b0; addr_i = 32'h10;
    @(negedge clk);
    check("flush_no_ack", 32'(ack_o), 0);
    check("flush_no_memreq", 32'(mem_req_o), 0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    model_clear();
    check_op("postflush", 1'b0, 32'h10, 0);
    check_op("postflush", 1'b0, 32'h30, 0);
    check_op("postflush", 1'b0, 32'h50, 0);
    check_op("postflush", 1'b0, 32'h70, 0);
    check_op("postflush", 1'b0, 32'h90, 0);
    check_op("postflush", 1'b0, 32'h10, 0);

    // Reset during REFILL
    mem_lat = 5;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h400;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_pre_memreq", 32'(mem_req_o), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_memreq", 32'(mem_req_o), 0);
    check("rst_mid_ack", 32'(ack_o), 0);
    check("rst_mid_hits", hit_count_o, 0);
    check("rst_mid_misses", miss_count_o, 0);
    req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    m_hits = 0; m_misses = 0;
    @(posedge clk); #1;
    mem_lat = 0;
    check_op("postrst", 1'b0, 32'h400, 0);
    check_op("postrst", 1'b0, 32'h400, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic        w;
      mem_lat = $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) begin
        flush_i = 1'b1;
        @(negedge clk);
        check("rand_flush_no_ack", 32'(ack_o), 0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        model_clear();
      end else begin
        a = (32'($urandom_range(0, 5)) << 5) | (32'($urandom_range(0, 7)) << 2)
            | 32'($urandom_range(0, 3));
        w = ($urandom_range(0, 3) == 0);
        check_op("rand", w, a, $urandom);
      end
    end
    check("final_hits", hit_count_o, stat_exp(m_hits));
    check("final_misses", miss_count_o, stat_exp(m_misses));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
